// File: rtl/core_id_decode_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : core_id_decode_stage_pkg                                         |
// | Purpose : Shared widths, unit-bus bit indices, RV32 opcode encodings and   |
// |           small helper functions for the ID decode stage.                  |
// | Ports   : none (package)                                                   |
// | Macros  : CORE_RV32M_EN enables M-extension decode (see decode comb)       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package core_id_decode_stage_pkg;

   localparam int CORE_INST_WIDTH     = 32;
   localparam int CORE_RFIDX_WIDTH    = 5;

   // Branch/jump unit bus. Unsigned compares reuse BLT/BGE plus the BUNS flag.
   localparam int CORE_BJ_INST_JAL    = 0;
   localparam int CORE_BJ_INST_JALR   = 1;
   localparam int CORE_BJ_INST_BEQ    = 2;
   localparam int CORE_BJ_INST_BNE    = 3;
   localparam int CORE_BJ_INST_BLT    = 4;
   localparam int CORE_BJ_INST_BGE    = 5;
   localparam int CORE_BJ_INST_BUNS   = 6;
   localparam int CORE_BJ_INST_WIDTH  = 7;

   // ALU bus. OP2IMM selects the immediate as operand 2, OP1PC selects PC as operand 1.
   localparam int CORE_ALU_INST_ADD    = 0;
   localparam int CORE_ALU_INST_SUB    = 1;
   localparam int CORE_ALU_INST_XOR    = 2;
   localparam int CORE_ALU_INST_SLL    = 3;
   localparam int CORE_ALU_INST_SRL    = 4;
   localparam int CORE_ALU_INST_SRA    = 5;
   localparam int CORE_ALU_INST_OR     = 6;
   localparam int CORE_ALU_INST_AND    = 7;
   localparam int CORE_ALU_INST_SLT    = 8;
   localparam int CORE_ALU_INST_SLTU   = 9;
   localparam int CORE_ALU_INST_LUI    = 10;
   localparam int CORE_ALU_INST_OP2IMM = 11;
   localparam int CORE_ALU_INST_OP1PC  = 12;
   localparam int CORE_ALU_INST_FENCE  = 13;
   localparam int CORE_ALU_INST_WIDTH  = 14;

   // LSU bus. SIZE is func3[1:0] (00 byte, 01 half, 10 word); USIGN is func3[2].
   localparam int CORE_LSU_INST_LOAD     = 0;
   localparam int CORE_LSU_INST_STORE    = 1;
   localparam int CORE_LSU_INST_SIZE_LSB = 2;
   localparam int CORE_LSU_INST_SIZE_MSB = 3;
   localparam int CORE_LSU_INST_USIGN    = 4;
   localparam int CORE_LSU_INST_WIDTH    = 5;

   // CSR/system bus.
   localparam int CORE_CSR_INST_RW     = 0;
   localparam int CORE_CSR_INST_RS     = 1;
   localparam int CORE_CSR_INST_RC     = 2;
   localparam int CORE_CSR_INST_IMM    = 3;
   localparam int CORE_CSR_INST_ECALL  = 4;
   localparam int CORE_CSR_INST_EBREAK = 5;
   localparam int CORE_CSR_INST_WIDTH  = 6;

   // M-extension bus: one-hot, bit index equals func3.
   localparam int CORE_MUL_INST_MUL    = 0;
   localparam int CORE_MUL_INST_MULH   = 1;
   localparam int CORE_MUL_INST_MULHSU = 2;
   localparam int CORE_MUL_INST_MULHU  = 3;
   localparam int CORE_MUL_INST_DIV    = 4;
   localparam int CORE_MUL_INST_DIVU   = 5;
   localparam int CORE_MUL_INST_REM    = 6;
   localparam int CORE_MUL_INST_REMU   = 7;
   localparam int CORE_MUL_INST_WIDTH  = 8;

   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [6:0] {
      OPC_LUI     = 7'b0110111,
      OPC_AUIPC   = 7'b0010111,
      OPC_JAL     = 7'b1101111,
      OPC_JALR    = 7'b1100111,
      OPC_BRANCH  = 7'b1100011,
      OPC_LOAD    = 7'b0000011,
      OPC_STORE   = 7'b0100011,
      OPC_OPIMM   = 7'b0010011,
      OPC_OP      = 7'b0110011,
      OPC_MISCMEM = 7'b0001111,
      OPC_SYSTEM  = 7'b1110011
   } opcode_e;

   // Shared func3 -> ALU op mapping for OP and OP-IMM; alt selects SUB/SRA.
   function automatic logic [CORE_ALU_INST_WIDTH-1:0] alu_func3_onehot(input logic [2:0] f3,
                                                                     input logic       alt);
      logic [CORE_ALU_INST_WIDTH-1:0] v;
      v = '0;
      case (f3)
         3'b000:  v[alt ? CORE_ALU_INST_SUB : CORE_ALU_INST_ADD] = 1'b1;
         3'b001:  v[CORE_ALU_INST_SLL]  = 1'b1;
         3'b010:  v[CORE_ALU_INST_SLT]  = 1'b1;
         3'b011:  v[CORE_ALU_INST_SLTU] = 1'b1;
         3'b100:  v[CORE_ALU_INST_XOR]  = 1'b1;
         3'b101:  v[alt ? CORE_ALU_INST_SRA : CORE_ALU_INST_SRL] = 1'b1;
         3'b110:  v[CORE_ALU_INST_OR]   = 1'b1;
         default: v[CORE_ALU_INST_AND]  = 1'b1;
      endcase
      return v;
   endfunction

   function automatic logic [CORE_MUL_INST_WIDTH-1:0] mul_onehot(input logic [2:0] f3);
      return CORE_MUL_INST_WIDTH'(1) << f3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/core_id_decode_comb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : core_id_decode_comb                                              |
// | Purpose : Pure combinational RV32I(+M) instruction decoder.                |
// | Ports   : inst      in  instruction word                                   |
// |           rs1/rs2/rd_idx out register indices                              |
// |           rd_wen    out writeback enable (0 for rd==0 or illegal)          |
// |           imm       out sign-extended immediate                            |
// |           bj/alu/lsu/csr/mul_bus out unit opcode buses (0 when illegal)    |
// |           illegal   out undefined encoding                                 |
// |           ebreak    out instruction is EBREAK                              |
// | Macros  : CORE_RV32M_EN - decode MUL/DIV/REM onto mul_bus                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module core_id_decode_comb
   import core_id_decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [CORE_INST_WIDTH-1:0]     inst,
   output logic [CORE_RFIDX_WIDTH-1:0]    rs1_idx,
   output logic [CORE_RFIDX_WIDTH-1:0]    rs2_idx,
   output logic [CORE_RFIDX_WIDTH-1:0]    rd_idx,
   output logic                           rd_wen,
   output logic [XLEN-1:0]                imm,
   output logic [CORE_BJ_INST_WIDTH-1:0]  bj_bus,
   output logic [CORE_ALU_INST_WIDTH-1:0] alu_bus,
   output logic [CORE_LSU_INST_WIDTH-1:0] lsu_bus,
   output logic [CORE_CSR_INST_WIDTH-1:0] csr_bus,
   output logic [CORE_MUL_INST_WIDTH-1:0] mul_bus,
   output logic                           illegal,
   output logic                           ebreak
);

   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode  = inst[6:0];
   assign func3   = inst[14:12];
   assign func7   = inst[31:25];
   assign rd_idx  = inst[11:7];
   assign rs1_idx = inst[19:15];
   assign rs2_idx = inst[24:20];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   logic                           legal;
   logic                           wen;
   logic [31:0]                    imm32;
   logic [CORE_BJ_INST_WIDTH-1:0]  bj;
   logic [CORE_ALU_INST_WIDTH-1:0] alu;
   logic [CORE_LSU_INST_WIDTH-1:0] lsu;
   logic [CORE_CSR_INST_WIDTH-1:0] csr;
   logic [CORE_MUL_INST_WIDTH-1:0] mul;

   always_comb begin
      legal = 1'b0;
      wen   = 1'b0;
      imm32 = '0;
      bj    = '0;
      alu   = '0;
      lsu   = '0;
      csr   = '0;
      mul   = '0;
      case (opcode)
         OPC_LUI: begin
            legal = 1'b1;
            wen   = 1'b1;
            imm32 = imm_u;
            alu[CORE_ALU_INST_LUI]    = 1'b1;
            alu[CORE_ALU_INST_OP2IMM] = 1'b1;
         end
         OPC_AUIPC: begin
            legal = 1'b1;
            wen   = 1'b1;
            imm32 = imm_u;
            alu[CORE_ALU_INST_ADD]    = 1'b1;
            alu[CORE_ALU_INST_OP2IMM] = 1'b1;
            alu[CORE_ALU_INST_OP1PC]  = 1'b1;
         end
         OPC_JAL: begin
            legal = 1'b1;
            wen   = 1'b1;
            imm32 = imm_j;
            bj[CORE_BJ_INST_JAL] = 1'b1;
         end
         OPC_JALR: begin
            legal = (func3 == 3'b000);
            wen   = 1'b1;
            imm32 = imm_i;
            bj[CORE_BJ_INST_JALR] = 1'b1;
         end
         OPC_BRANCH: begin
            legal = 1'b1;
            imm32 = imm_b;
            case (func3)
               3'b000:  bj[CORE_BJ_INST_BEQ] = 1'b1;
               3'b001:  bj[CORE_BJ_INST_BNE] = 1'b1;
               3'b100:  bj[CORE_BJ_INST_BLT] = 1'b1;
               3'b101:  bj[CORE_BJ_INST_BGE] = 1'b1;
               3'b110: begin
                  bj[CORE_BJ_INST_BLT]  = 1'b1;
                  bj[CORE_BJ_INST_BUNS] = 1'b1;
               end
               3'b111: begin
                  bj[CORE_BJ_INST_BGE]  = 1'b1;
                  bj[CORE_BJ_INST_BUNS] = 1'b1;
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            // LB/LH/LW/LBU/LHU; size 11 and LWU do not exist in RV32.
            legal = (func3[1:0] != 2'b11) && !(func3[2] && func3[1]);
            wen   = 1'b1;
            imm32 = imm_i;
            lsu[CORE_LSU_INST_LOAD]  = 1'b1;
            lsu[CORE_LSU_INST_SIZE_MSB:CORE_LSU_INST_SIZE_LSB] = func3[1:0];
            lsu[CORE_LSU_INST_USIGN] = func3[2];
         end
         OPC_STORE: begin
            legal = !func3[2] && (func3[1:0] != 2'b11);
            imm32 = imm_s;
            lsu[CORE_LSU_INST_STORE] = 1'b1;
            lsu[CORE_LSU_INST_SIZE_MSB:CORE_LSU_INST_SIZE_LSB] = func3[1:0];
         end
         OPC_OPIMM: begin
            // Shift-immediates carry func7 in imm[11:5]; only SRAI may use the alt code.
            if (func3 == 3'b001)
               legal = (func7 == F7_ZERO);
            else if (func3 == 3'b101)
               legal = (func7 == F7_ZERO) || (func7 == F7_ALT);
            else
               legal = 1'b1;
            wen   = 1'b1;
            imm32 = imm_i;
            alu   = alu_func3_onehot(func3, (func3 == 3'b101) && func7[5]);
            alu[CORE_ALU_INST_OP2IMM] = 1'b1;
         end
         OPC_OP: begin
            if (func7 == F7_ZERO) begin
               legal = 1'b1;
               wen   = 1'b1;
               alu   = alu_func3_onehot(func3, 1'b0);
            end else if (func7 == F7_ALT) begin
               legal = (func3 == 3'b000) || (func3 == 3'b101);
               wen   = 1'b1;
               alu   = alu_func3_onehot(func3, 1'b1);
            end else if (func7 == F7_MULDIV) begin
`ifdef CORE_RV32M_EN
               legal = 1'b1;
               wen   = 1'b1;
               mul   = mul_onehot(func3);
`else
               legal = 1'b0;
`endif
            end
         end
         OPC_MISCMEM: begin
            // FENCE / FENCE.I retire as no-ops in this in-order core.
            legal = (func3[2:1] == 2'b00);
            alu[CORE_ALU_INST_FENCE] = 1'b1;
         end
         OPC_SYSTEM: begin
            if (func3 == 3'b000) begin
               if (inst[31:7] == 25'h0) begin
                  legal = 1'b1;
                  csr[CORE_CSR_INST_ECALL] = 1'b1;
               end else if (inst[31:7] == {12'h001, 13'h0}) begin
                  legal = 1'b1;
                  csr[CORE_CSR_INST_EBREAK] = 1'b1;
               end
            end else if (func3 != 3'b100) begin
               legal = 1'b1;
               wen   = 1'b1;
               imm32 = {20'b0, inst[31:20]};     // CSR address
               csr[CORE_CSR_INST_RW]  = (func3[1:0] == 2'b01);
               csr[CORE_CSR_INST_RS]  = (func3[1:0] == 2'b10);
               csr[CORE_CSR_INST_RC]  = (func3[1:0] == 2'b11);
               csr[CORE_CSR_INST_IMM] = func3[2];
            end
         end
         default: legal = 1'b0;
      endcase
   end

   // opcode[1:0] != 11 never matches a listed opcode, so it falls to illegal above.
   assign illegal = !legal;
   assign rd_wen  = legal && wen && (rd_idx != '0);
   assign imm     = XLEN'($signed(imm32));
   assign bj_bus  = legal ? bj  : '0;
   assign alu_bus = legal ? alu : '0;
   assign lsu_bus = legal ? lsu : '0;
   assign csr_bus = legal ? csr : '0;
   assign mul_bus = legal ? mul : '0;
   assign ebreak  = csr_bus[CORE_CSR_INST_EBREAK];

endmodule
`default_nettype wire

// File: rtl/core_id_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : core_id_decode_stage                                             |
// | Purpose : Registered, back-pressured ID stage. {pc,inst} pairs are queued  |
// |           in an IBUF_DEPTH FIFO; the head (or a bypassing input) is        |
// |           decoded into a valid/ready output register.                      |
// | Ports   : clk, rst_n (async active-low), i_flush                           |
// |           i_valid/o_ready/i_pc/i_inst   upstream handshake and payload     |
// |           o_valid/i_ready               downstream handshake               |
// |           o_pc, o_rs1/rs2/rd_idx, o_rd_wen, o_imm, o_bj/alu/lsu/csr/mul_bus|
// |           o_illegal, o_ebreak_sim       decoded payload                    |
// | Macros  : CORE_RV32M_EN - enable M-extension decode                        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module core_id_decode_stage
   import core_id_decode_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int IBUF_DEPTH = 2      // power of 2, >= 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_flush,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic [XLEN-1:0]                i_pc,
   input  logic [CORE_INST_WIDTH-1:0]     i_inst,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic [XLEN-1:0]                o_pc,
   output logic [CORE_RFIDX_WIDTH-1:0]    o_rs1_idx,
   output logic [CORE_RFIDX_WIDTH-1:0]    o_rs2_idx,
   output logic [CORE_RFIDX_WIDTH-1:0]    o_rd_idx,
   output logic                           o_rd_wen,
   output logic [XLEN-1:0]                o_imm,
   output logic [CORE_BJ_INST_WIDTH-1:0]  o_bj_bus,
   output logic [CORE_ALU_INST_WIDTH-1:0] o_alu_bus,
   output logic [CORE_LSU_INST_WIDTH-1:0] o_lsu_bus,
   output logic [CORE_CSR_INST_WIDTH-1:0] o_csr_bus,
   output logic [CORE_MUL_INST_WIDTH-1:0] o_mul_bus,
   output logic                           o_illegal,
   output logic                           o_ebreak_sim
);

   localparam int PTR_W = $clog2(IBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IBUF_DEPTH);

   logic [XLEN-1:0]            q_pc   [IBUF_DEPTH];
   logic [CORE_INST_WIDTH-1:0] q_inst [IBUF_DEPTH];
   logic [PTR_W-1:0]           wr_ptr, rd_ptr;
   logic [CNT_W-1:0]           count;
   logic                       ebreak_q;

   logic q_empty, out_free, accept, pop, bypass, push, load;

   assign o_ready  = (count < DEPTH_CNT);
   assign q_empty  = (count == '0);
   assign out_free = !o_valid || i_ready;
   assign accept   = i_valid && o_ready && !i_flush;
   assign pop      = out_free && !q_empty && !i_flush;
   // Input skips the queue only when nothing older is waiting ahead of it.
   assign bypass   = accept && q_empty && out_free;
   assign push     = accept && !bypass;
   assign load     = pop || bypass;

   // Output register input mux: queue head has priority to keep FIFO order.
   logic [XLEN-1:0]            sel_pc;
   logic [CORE_INST_WIDTH-1:0] sel_inst;
   assign sel_pc   = q_empty ? i_pc   : q_pc[rd_ptr];
   assign sel_inst = q_empty ? i_inst : q_inst[rd_ptr];

   logic [CORE_RFIDX_WIDTH-1:0]    dec_rs1, dec_rs2, dec_rd;
   logic                           dec_rd_wen, dec_illegal, dec_ebreak;
   logic [XLEN-1:0]                dec_imm;
   logic [CORE_BJ_INST_WIDTH-1:0]  dec_bj;
   logic [CORE_ALU_INST_WIDTH-1:0] dec_alu;
   logic [CORE_LSU_INST_WIDTH-1:0] dec_lsu;
   logic [CORE_CSR_INST_WIDTH-1:0] dec_csr;
   logic [CORE_MUL_INST_WIDTH-1:0] dec_mul;

   core_id_decode_comb #(.XLEN(XLEN)) u_decode (
      .inst    (sel_inst),
      .rs1_idx (dec_rs1),
      .rs2_idx (dec_rs2),
      .rd_idx  (dec_rd),
      .rd_wen  (dec_rd_wen),
      .imm     (dec_imm),
      .bj_bus  (dec_bj),
      .alu_bus (dec_alu),
      .lsu_bus (dec_lsu),
      .csr_bus (dec_csr),
      .mul_bus (dec_mul),
      .illegal (dec_illegal),
      .ebreak  (dec_ebreak)
   );

   // Queue storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]   <= i_pc;
         q_inst[wr_ptr] <= i_inst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (pop && !push)
            count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid   <= 1'b0;
         o_pc      <= '0;
         o_rs1_idx <= '0;
         o_rs2_idx <= '0;
         o_rd_idx  <= '0;
         o_rd_wen  <= 1'b0;
         o_imm     <= '0;
         o_bj_bus  <= '0;
         o_alu_bus <= '0;
         o_lsu_bus <= '0;
         o_csr_bus <= '0;
         o_mul_bus <= '0;
         o_illegal <= 1'b0;
         ebreak_q  <= 1'b0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (out_free) begin
         o_valid <= load;
         if (load) begin
            o_pc      <= sel_pc;
            o_rs1_idx <= dec_rs1;
            o_rs2_idx <= dec_rs2;
            o_rd_idx  <= dec_rd;
            o_rd_wen  <= dec_rd_wen;
            o_imm     <= dec_imm;
            o_bj_bus  <= dec_bj;
            o_alu_bus <= dec_alu;
            o_lsu_bus <= dec_lsu;
            o_csr_bus <= dec_csr;
            o_mul_bus <= dec_mul;
            o_illegal <= dec_illegal;
            ebreak_q  <= dec_ebreak;
         end
      end
   end

   assign o_ebreak_sim = o_valid && ebreak_q;

endmodule
`default_nettype wire

// File: tb/tb_core_id_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_core_id_decode_stage                                          |
// | Purpose : Directed self-checking bench for core_id_decode_stage.           |
// | Macros  : CORE_RV32M_EN selects the expected M-extension results           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_core_id_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_flush;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_pc;
   logic [31:0] i_inst;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_pc;
   logic [4:0]  o_rs1_idx, o_rs2_idx, o_rd_idx;
   logic        o_rd_wen;
   logic [31:0] o_imm;
   logic [6:0]  o_bj_bus;
   logic [13:0] o_alu_bus;
   logic [4:0]  o_lsu_bus;
   logic [5:0]  o_csr_bus;
   logic [7:0]  o_mul_bus;
   logic        o_illegal;
   logic        o_ebreak_sim;

   int n_tests = 0;
   int n_fail  = 0;

   // Hand-derived bus values
   localparam logic [13:0] ALU_ADDI = 14'h0801;   // ADD | OP2IMM
   localparam logic [13:0] ALU_LUI  = 14'h0C00;   // LUI | OP2IMM
   localparam logic [13:0] ALU_SUB  = 14'h0002;
   localparam logic [6:0]  BJ_BLTU  = 7'h50;      // BLT | BUNS
   localparam logic [4:0]  LSU_SW   = 5'h0A;      // STORE | size=10
   localparam logic [5:0]  CSR_EBRK = 6'h20;

   always #5 clk = ~clk;

   core_id_decode_stage #(.XLEN(32), .IBUF_DEPTH(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_flush      (i_flush),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_pc         (i_pc),
      .i_inst       (i_inst),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_pc         (o_pc),
      .o_rs1_idx    (o_rs1_idx),
      .o_rs2_idx    (o_rs2_idx),
      .o_rd_idx     (o_rd_idx),
      .o_rd_wen     (o_rd_wen),
      .o_imm        (o_imm),
      .o_bj_bus     (o_bj_bus),
      .o_alu_bus    (o_alu_bus),
      .o_lsu_bus    (o_lsu_bus),
      .o_csr_bus    (o_csr_bus),
      .o_mul_bus    (o_mul_bus),
      .o_illegal    (o_illegal),
      .o_ebreak_sim (o_ebreak_sim)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one {pc,inst} for a single cycle (called 1 unit after an edge).
   task automatic send(input logic [31:0] pc, input logic [31:0] inst);
      i_valid = 1'b1;
      i_pc    = pc;
      i_inst  = inst;
      tick();
      i_valid = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_pc    = '0;
      i_inst  = '0;
      i_ready = 1'b0;

      // 1: reset
      repeat (3) tick();
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 1);
      check("rst_imm",   o_imm,   0);
      check("rst_pc",    o_pc,    0);
      rst_n = 1'b1;
      tick();
      check("post_rst_valid", o_valid, 0);

      // 2: addi x1,x0,5 bypasses into the output register in one cycle
      i_ready = 1'b1;
      send(32'h8000_0000, 32'h0050_0093);
      check("addi_valid", o_valid,   1);
      check("addi_rd",    o_rd_idx,  1);
      check("addi_imm",   o_imm,     5);
      check("addi_alu",   o_alu_bus, ALU_ADDI);
      check("addi_wen",   o_rd_wen,  1);
      check("addi_pc",    o_pc,      32'h8000_0000);
      check("addi_ill",   o_illegal, 0);
      tick();
      check("addi_consumed", o_valid, 0);

      // 3: back-pressure, fill queue, then drain in order
      i_ready = 1'b0;
      send(32'h100, 32'h0010_0113);   // addi x2,x0,1
      send(32'h104, 32'h0020_0193);   // addi x3,x0,2
      send(32'h108, 32'h0030_0213);   // addi x4,x0,3
      check("full_ready", o_ready, 0);
      check("stall_valid", o_valid, 1);
      check("stall_pc",   o_pc,    32'h100);
      check("stall_imm",  o_imm,   1);
      tick();
      check("hold_pc",    o_pc,    32'h100);
      i_ready = 1'b1;
      tick();
      check("drain1_pc",    o_pc,    32'h104);
      check("drain1_imm",   o_imm,   2);
      check("drain1_ready", o_ready, 1);
      tick();
      check("drain2_pc",    o_pc,     32'h108);
      check("drain2_rd",    o_rd_idx, 4);
      check("drain2_valid", o_valid,  1);
      tick();
      check("drain_done", o_valid, 0);

      // 4: flush a full queue while an input is offered
      i_ready = 1'b0;
      send(32'h200, 32'h0010_0113);
      send(32'h204, 32'h0010_0113);
      send(32'h208, 32'h0010_0113);
      check("pre_flush_ready", o_ready, 0);
      i_flush = 1'b1;
      i_valid = 1'b1;
      i_pc    = 32'h20C;
      i_inst  = 32'h0010_0113;
      tick();
      i_flush = 1'b0;
      i_valid = 1'b0;
      check("flush_valid", o_valid, 0);
      check("flush_ready", o_ready, 1);
      i_ready = 1'b1;
      tick();
      check("flush_nothing1", o_valid, 0);
      tick();
      check("flush_nothing2", o_valid, 0);

      // 5: decode corner cases
      send(32'h300, 32'h0000_0000);
      check("zero_ill", o_illegal, 1);
      check("zero_wen", o_rd_wen,  0);
      check("zero_alu", o_alu_bus, 0);
      send(32'h304, 32'h0000_0013);
      check("nop_ill", o_illegal, 0);
      check("nop_wen", o_rd_wen,  0);
      check("nop_alu", o_alu_bus, ALU_ADDI);
      send(32'h308, 32'h1234_52B7);
      check("lui_imm", o_imm,     32'h1234_5000);
      check("lui_wen", o_rd_wen,  1);
      check("lui_alu", o_alu_bus, ALU_LUI);
      send(32'h30C, 32'hFFF0_0093);   // addi x1,x0,-1
      check("neg_imm", o_imm, 32'hFFFF_FFFF);
      send(32'h310, 32'h4031_00B3);   // sub x1,x2,x3
      check("sub_alu", o_alu_bus, ALU_SUB);
      check("sub_rs2", o_rs2_idx, 3);
      send(32'h314, 32'h4031_10B3);   // alt func7 on SLL -> illegal
      check("sllalt_ill", o_illegal, 1);
      check("sllalt_wen", o_rd_wen,  0);
      send(32'h318, 32'h0020_E463);   // bltu x1,x2,+8
      check("bltu_bj",  o_bj_bus, BJ_BLTU);
      check("bltu_imm", o_imm,    8);
      check("bltu_wen", o_rd_wen, 0);
      send(32'h31C, 32'h0020_A223);   // sw x2,4(x1)
      check("sw_lsu", o_lsu_bus, LSU_SW);
      check("sw_imm", o_imm,     4);
      send(32'h320, 32'h0010_0073);   // ebreak
      check("ebreak_csr", o_csr_bus,    CSR_EBRK);
      check("ebreak_sim", o_ebreak_sim, 1);
      check("ebreak_wen", o_rd_wen,     0);

      // 6: mul x3,x1,x2
      send(32'h324, 32'h0220_81B3);
`ifdef CORE_RV32M_EN
      check("mul_bus", o_mul_bus, 8'h01);
      check("mul_wen", o_rd_wen,  1);
      check("mul_ill", o_illegal, 0);
`else
      check("mul_ill", o_illegal, 1);
      check("mul_wen", o_rd_wen,  0);
      check("mul_bus", o_mul_bus, 0);
`endif
      check("mul_alu", o_alu_bus, 0);

      // asynchronous reset mid-operation
      i_ready = 1'b0;
      send(32'h400, 32'h0050_0093);
      check("pre_arst_valid", o_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", o_valid, 0);
      check("arst_pc",    o_pc,    0);
      check("arst_ready", o_ready, 1);
      tick();
      rst_n = 1'b1;
      tick();
      check("arst_after", o_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
